// File: rtl/seq_display.sv
// Plays the round's colour sequence on the LEDs by stepping the external counter.
// Optional macro GENIUS_SPEEDUP_EN shortens the lit time as the level rises.
module seq_display #(
    parameter int unsigned ON_CYC     = 8,
    parameter int unsigned OFF_CYC    = 4,
    parameter logic [31:0] SEQ_ROM    = 32'h1B1B_E4E4
`ifdef GENIUS_SPEEDUP_EN
    ,
    parameter int unsigned SPEED_STEP = 1,
    parameter int unsigned MIN_ON_CYC = 2
`endif
) (
    input  logic       clk,
    input  logic       R,
    input  logic       start,
    input  logic [3:0] level,
    input  logic [3:0] step_idx,
    input  logic       tc,
    output logic       cnt_clr,
    output logic       step_en,
    output logic [3:0] leds,
    output logic       busy,
    output logic       done
);

    localparam int unsigned MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int unsigned TW      = $clog2(MAX_CYC) + 1;

    typedef enum logic [2:0] {
        IDLE, CLEAR, FETCH, LATCH, SHOW, GAP, DONE
    } state_t;

    state_t        state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic [3:0]    steps, steps_d;
    logic [1:0]    colour, colour_d;
    logic          tc_q, tc_d;
    logic          cnt_clr_d, step_en_d, busy_d, done_d;
    logic [3:0]    leds_d;
    logic [1:0]    rom_col;
    logic [TW-1:0] on_len;

    assign rom_col = SEQ_ROM[{step_idx, 1'b0} +: 2];

`ifdef GENIUS_SPEEDUP_EN
    logic [3:0]        level_q, level_d;
    logic signed [7:0] on_raw;

    // Lit time shrinks with the level, clamped at the floor
    always_comb begin
        on_raw = $signed(8'(ON_CYC)) - $signed(8'(level_q) * 8'(SPEED_STEP));
        if (on_raw < $signed(8'(MIN_ON_CYC)))
            on_len = TW'(MIN_ON_CYC);
        else
            on_len = TW'(on_raw);
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) level_q <= '0;
        else   level_q <= level_d;
    end

    always_comb begin
        level_d = level_q;
        if (state == CLEAR) level_d = level;
    end
`else
    logic unused_level;

    assign on_len       = TW'(ON_CYC);
    assign unused_level = ^level;
`endif

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state   <= IDLE;
            timer   <= '0;
            steps   <= '0;
            colour  <= '0;
            tc_q    <= 1'b0;
            cnt_clr <= 1'b0;
            step_en <= 1'b0;
            leds    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            timer   <= timer_d;
            steps   <= steps_d;
            colour  <= colour_d;
            tc_q    <= tc_d;
            cnt_clr <= cnt_clr_d;
            step_en <= step_en_d;
            leds    <= leds_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next state plus the output values that go with it, so outputs line up with state
    always_comb begin
        state_d   = state;
        timer_d   = timer;
        steps_d   = steps;
        colour_d  = colour;
        tc_d      = tc_q;
        cnt_clr_d = 1'b0;
        step_en_d = 1'b0;
        leds_d    = '0;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        case (state)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d   = CLEAR;
                    cnt_clr_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            CLEAR: begin
                state_d   = FETCH;
                step_en_d = 1'b1;
                steps_d   = '0;
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                state_d  = SHOW;
                colour_d = rom_col;
                tc_d     = tc;
                steps_d  = (steps == 4'd15) ? steps : steps + 4'd1;
                timer_d  = on_len - TW'(1);
                leds_d   = 4'(1) << rom_col;
            end
            SHOW: begin
                if (timer == '0) begin
                    state_d = GAP;
                    timer_d = TW'(OFF_CYC - 1);
                end else begin
                    timer_d = timer - TW'(1);
                    leds_d  = 4'(1) << colour;
                end
            end
            GAP: begin
                if (timer == '0) begin
                    // Step guard stops level 0 before the counter wraps
                    if (tc_q || steps == 4'd15) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = FETCH;
                        step_en_d = 1'b1;
                    end
                end else begin
                    timer_d = timer - TW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_display.sv
// Randomised bench for seq_display with an attached step-counter model and a
// level-driven reference for colour order, lit length and step count.
module tb_seq_display;

`ifdef GENIUS_SPEEDUP_EN
    localparam int unsigned ON_CYC = 8;
`else
    localparam int unsigned ON_CYC = 4;
`endif
    localparam int unsigned OFF_CYC    = 2;
    localparam int unsigned SPEED_STEP = 2;
    localparam int unsigned MIN_ON_CYC = 2;
    localparam logic [31:0] SEQ_ROM    = 32'h1B1B_E4E4;

    logic       clk, R, start, tc;
    logic [3:0] level, step_idx, leds;
    logic       cnt_clr, step_en, busy, done;
    logic [3:0] cnt;

    int n_checks = 0;
    int n_fail   = 0;

    seq_display #(
        .ON_CYC(ON_CYC), .OFF_CYC(OFF_CYC), .SEQ_ROM(SEQ_ROM)
`ifdef GENIUS_SPEEDUP_EN
        , .SPEED_STEP(SPEED_STEP), .MIN_ON_CYC(MIN_ON_CYC)
`endif
    ) dut (
        .clk(clk), .R(R), .start(start), .level(level), .step_idx(step_idx),
        .tc(tc), .cnt_clr(cnt_clr), .step_en(step_en), .leds(leds),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached counter stage: cleared by cnt_clr, advanced by step_en
    always @(posedge clk or posedge R) begin
        if (R)            cnt <= '0;
        else if (cnt_clr) cnt <= '0;
        else if (step_en) cnt <= cnt + 4'd1;
    end
    assign step_idx = cnt;
    assign tc       = (cnt == level);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_steps(input int lvl);
        return (lvl == 0) ? 15 : lvl;
    endfunction

    function automatic int exp_leds(input int entry);
        logic [31:0] rom;
        rom = SEQ_ROM;
        return 1 << ((rom >> (2 * entry)) & 3);
    endfunction

    function automatic int exp_on(input int lvl);
`ifdef GENIUS_SPEEDUP_EN
        int v;
        v = int'(ON_CYC) - lvl * int'(SPEED_STEP);
        return (v < int'(MIN_ON_CYC)) ? int'(MIN_ON_CYC) : v;
`else
        return (lvl >= 0) ? int'(ON_CYC) : 0;
`endif
    endfunction

    task automatic play(input int lvl, input bit noise);
        int  cols[$];
        int  lens[$];
        int  gaps[$];
        int  lit_len, dark, n_en, n_clr, busy_drop;
        bit  seen_done;
        @(negedge clk);
        level = 4'(lvl);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("clear_pulse", 32'(cnt_clr), 1);
        check("busy_start", 32'(busy), 1);
        n_clr = 1; n_en = 0; lit_len = 0; dark = 0; busy_drop = 0; seen_done = 1'b0;
        for (int c = 0; c < 600 && !seen_done; c++) begin
            @(negedge clk);
            if (cnt_clr) n_clr++;
            if (step_en) n_en++;
            if (!busy)   busy_drop++;
            if (done) begin
                seen_done = 1'b1;
                start     = 1'b0;
                check("tail_dark", 32'(dark), OFF_CYC);
            end else begin
                if (noise) start = ($urandom_range(0, 3) == 0);
                if (leds != 4'd0) begin
                    if (lit_len == 0) begin
                        cols.push_back(int'(leds));
                        if (cols.size() == 1) check("lead_in", 32'(dark), 2);
                        else                  gaps.push_back(dark);
                    end
                    lit_len++;
                    dark = 0;
                end else begin
                    if (lit_len != 0) lens.push_back(lit_len);
                    lit_len = 0;
                    dark++;
                end
            end
        end
        start = 1'b0;
        check("done_seen", 32'(seen_done), 1);
        check("busy_hold", 32'(busy_drop), 0);
        check("step_en_count", 32'(n_en), 32'(exp_steps(lvl)));
        check("cnt_clr_count", 32'(n_clr), 1);
        check("steps_shown", 32'(cols.size()), 32'(exp_steps(lvl)));
        for (int i = 0; i < cols.size(); i++) begin
            check("colour", 32'(cols[i]), 32'(exp_leds(i + 1)));
            if (i < lens.size()) check("lit_len", 32'(lens[i]), 32'(exp_on(lvl)));
        end
        // Dark between steps spans GAP, FETCH and LATCH
        foreach (gaps[i]) check("step_gap", 32'(gaps[i]), OFF_CYC + 2);
        @(negedge clk);
        check("done_width", 32'(done), 0);
        check("busy_end", 32'(busy), 0);
    endtask

    initial begin
        int  lvl;
        bit  lit;
        R = 1'b1; start = 1'b0; level = 4'd0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({cnt_clr, step_en, leds, busy, done}), 0);
        R = 1'b0;

        // Abort mid-SHOW with an asynchronous reset
        @(negedge clk);
        level = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lit = 1'b0;
        for (int c = 0; c < 50 && !lit; c++) begin
            @(negedge clk);
            lit = (leds != 4'd0);
        end
        check("reach_show", 32'(lit), 1);
        @(negedge clk);
        R = 1'b1;
        #1;
        check("abort_leds", 32'(leds), 0);
        check("abort_busy", 32'(busy), 0);
        @(negedge clk);
        R = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("idle_after_abort", 32'({cnt_clr, step_en, leds, busy, done}), 0);
        end

        play(3, 1'b0);
        play(1, 1'b0);
        play(0, 1'b0);
        play(3, 1'b1);
        play(2, 1'b0);
        play(5, 1'b1);
        for (int k = 0; k < 6; k++) begin
            lvl = int'($urandom_range(0, 15));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            play(lvl, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
